// File: rtl/core_mem_161c_pkg.sv
// Shared definitions for the type 161C core memory model: cycle states,
// array geometry and port count.
package core_mem_161c_pkg;

  localparam int WORDS  = 16384;
  localparam int WIDTH  = 36;
  localparam int AW     = 14;          // word index width, ma bits 22..35
  localparam int MA_W   = 15;          // full ma field, bits 21..35
  localparam int NPORTS = 4;
  localparam int PW     = 2;           // port number width

  localparam logic [4:0] MEMSEL_DEFAULT = 5'd0;

  // Memory cycle sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_READ    = 3'd2,
    ST_RS      = 3'd3,
    ST_WAIT_WR = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6,
    ST_STOP    = 3'd7
  } state_t;

  // True when {sel[18:21], ma[21]} addresses this module
  function automatic logic module_selected(input logic [3:0] sel,
                                           input logic       ma_top,
                                           input logic [4:0] memsel);
    return ({sel, ma_top} == memsel);
  endfunction

endpackage

// File: rtl/core_mem_161c_arb.sv
// Four-way fixed-priority membus arbiter (p0 highest). A port that has been
// granted is marked served and cannot win again until its rq_cyc drops for
// at least one cycle, so a processor holding rq_cyc is not serviced twice.
module membus_port_arb
  import core_mem_161c_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] eligible,    // port qualifies apart from served
  input  logic [NPORTS-1:0] rq_cyc,      // raw cycle requests
  input  logic              arb_en,      // sequencer is idle and may accept
  output logic              grant_valid,
  output logic [NPORTS-1:0] grant_oh,
  output logic [PW-1:0]     grant_port,
  output logic [NPORTS-1:0] served
);

  logic [NPORTS-1:0] cand;

  assign cand = eligible & ~served;

  // Lowest-numbered pending candidate wins; scan from the top so it is last
  always_comb begin
    grant_oh   = '0;
    grant_port = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_oh    = '0;
        grant_oh[i] = arb_en;
        grant_port  = PW'(i);
      end
    end
    grant_valid = |grant_oh;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_served
      logic served_bit_reg;

      // Served is set on grant and cleared whenever the port drops rq_cyc
      always_ff @(posedge clk) begin
        if (reset) begin
          served_bit_reg <= 1'b0;
        end else if (!rq_cyc[gi]) begin
          served_bit_reg <= 1'b0;
        end else if (grant_oh[gi]) begin
          served_bit_reg <= 1'b1;
        end
      end

      assign served[gi] = served_bit_reg;
    end
  endgenerate

endmodule

// File: rtl/core_mem_161c.sv
// Type 161C four-port 16K x 36 core memory on the PDP-6 membus.
// Bit numbering: PDP-6 fields are carried in descending vectors with the
// PDP-6 MSB in the top bit: ma bit 21 is ma[14], bits 22..35 are ma[13:0];
// sel bits 18..21 are sel[3:0]; mb bit 0 is mb[35].
// Only the latched port ever sees nonzero outputs, so the wired-OR bus
// never carries two drivers.
module core_mem_161c
  import core_mem_161c_pkg::*;
#(
  parameter logic [4:0] MEMSEL = MEMSEL_DEFAULT
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             power,
  input  logic             sw_single_step,
  input  logic             sw_restart,
  // port 0
  input  logic             membus_rq_cyc_p0,
  input  logic             membus_rd_rq_p0,
  input  logic             membus_wr_rq_p0,
  input  logic [MA_W-1:0]  membus_ma_p0,
  input  logic [3:0]       membus_sel_p0,
  input  logic             membus_fmc_select_p0,
  input  logic [WIDTH-1:0] membus_mb_in_p0,
  input  logic             membus_wr_rs_p0,
  output logic [WIDTH-1:0] membus_mb_out_p0,
  output logic             membus_addr_ack_p0,
  output logic             membus_rd_rs_p0,
  // port 1
  input  logic             membus_rq_cyc_p1,
  input  logic             membus_rd_rq_p1,
  input  logic             membus_wr_rq_p1,
  input  logic [MA_W-1:0]  membus_ma_p1,
  input  logic [3:0]       membus_sel_p1,
  input  logic             membus_fmc_select_p1,
  input  logic [WIDTH-1:0] membus_mb_in_p1,
  input  logic             membus_wr_rs_p1,
  output logic [WIDTH-1:0] membus_mb_out_p1,
  output logic             membus_addr_ack_p1,
  output logic             membus_rd_rs_p1,
  // port 2
  input  logic             membus_rq_cyc_p2,
  input  logic             membus_rd_rq_p2,
  input  logic             membus_wr_rq_p2,
  input  logic [MA_W-1:0]  membus_ma_p2,
  input  logic [3:0]       membus_sel_p2,
  input  logic             membus_fmc_select_p2,
  input  logic [WIDTH-1:0] membus_mb_in_p2,
  input  logic             membus_wr_rs_p2,
  output logic [WIDTH-1:0] membus_mb_out_p2,
  output logic             membus_addr_ack_p2,
  output logic             membus_rd_rs_p2,
  // port 3
  input  logic             membus_rq_cyc_p3,
  input  logic             membus_rd_rq_p3,
  input  logic             membus_wr_rq_p3,
  input  logic [MA_W-1:0]  membus_ma_p3,
  input  logic [3:0]       membus_sel_p3,
  input  logic             membus_fmc_select_p3,
  input  logic [WIDTH-1:0] membus_mb_in_p3,
  input  logic             membus_wr_rs_p3,
  output logic [WIDTH-1:0] membus_mb_out_p3,
  output logic             membus_addr_ack_p3,
  output logic             membus_rd_rs_p3
);

  // Storage; contents survive reset and power loss
  logic [WIDTH-1:0] core [0:WORDS-1];

  // Per-port views of the bus so the rest of the logic can loop over ports
  logic [NPORTS-1:0] rq_cyc;
  logic [NPORTS-1:0] rd_rq;
  logic [NPORTS-1:0] wr_rq;
  logic [NPORTS-1:0] fmc_sel;
  logic [NPORTS-1:0] wr_rs;
  logic [MA_W-1:0]   ma_arr    [NPORTS];
  logic [3:0]        sel_arr   [NPORTS];
  logic [WIDTH-1:0]  mb_in_arr [NPORTS];

  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] addr_ack_vec;
  logic [NPORTS-1:0] rd_rs_vec;
  logic [WIDTH-1:0]  mb_out_arr [NPORTS];

  // Arbiter results
  logic              grant_valid;
  logic [NPORTS-1:0] grant_oh;
  logic [PW-1:0]     grant_port;
  logic [NPORTS-1:0] served;
  logic [AW-1:0]     grant_addr;
  logic              grant_rd;
  logic              grant_wr;

  // Sequencer state and latched request
  state_t            state_reg;
  logic [NPORTS-1:0] port_oh_reg;
  logic [AW-1:0]     addr_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              addr_ack_reg;
  logic              rd_rs_reg;
  logic              drive_reg;     // mb_out carries data_reg
  logic [WIDTH-1:0]  data_reg;

  // Latched-port selections
  logic              wr_rs_sel;
  logic [WIDTH-1:0]  mb_in_sel;
  logic              ram_we;

  assign rq_cyc  = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
  assign rd_rq   = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
  assign wr_rq   = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
  assign fmc_sel = {membus_fmc_select_p3, membus_fmc_select_p2,
                    membus_fmc_select_p1, membus_fmc_select_p0};
  assign wr_rs   = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};

  assign ma_arr[0]    = membus_ma_p0;
  assign ma_arr[1]    = membus_ma_p1;
  assign ma_arr[2]    = membus_ma_p2;
  assign ma_arr[3]    = membus_ma_p3;
  assign sel_arr[0]   = membus_sel_p0;
  assign sel_arr[1]   = membus_sel_p1;
  assign sel_arr[2]   = membus_sel_p2;
  assign sel_arr[3]   = membus_sel_p3;
  assign mb_in_arr[0] = membus_mb_in_p0;
  assign mb_in_arr[1] = membus_mb_in_p1;
  assign mb_in_arr[2] = membus_mb_in_p2;
  assign mb_in_arr[3] = membus_mb_in_p3;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      // A bare rq_cyc without rd or wr is not a request
      assign eligible[gi] = power & rq_cyc[gi] & ~fmc_sel[gi]
                          & module_selected(sel_arr[gi], ma_arr[gi][MA_W-1], MEMSEL)
                          & (rd_rq[gi] | wr_rq[gi]);

      // Outputs are gated by power so a dead module is silent immediately
      assign addr_ack_vec[gi] = power & addr_ack_reg & port_oh_reg[gi];
      assign rd_rs_vec[gi]    = power & rd_rs_reg & port_oh_reg[gi];
      assign mb_out_arr[gi]   = (power & drive_reg & port_oh_reg[gi]) ? data_reg : '0;
    end
  endgenerate

  assign membus_addr_ack_p0 = addr_ack_vec[0];
  assign membus_addr_ack_p1 = addr_ack_vec[1];
  assign membus_addr_ack_p2 = addr_ack_vec[2];
  assign membus_addr_ack_p3 = addr_ack_vec[3];
  assign membus_rd_rs_p0    = rd_rs_vec[0];
  assign membus_rd_rs_p1    = rd_rs_vec[1];
  assign membus_rd_rs_p2    = rd_rs_vec[2];
  assign membus_rd_rs_p3    = rd_rs_vec[3];
  assign membus_mb_out_p0   = mb_out_arr[0];
  assign membus_mb_out_p1   = mb_out_arr[1];
  assign membus_mb_out_p2   = mb_out_arr[2];
  assign membus_mb_out_p3   = mb_out_arr[3];

  membus_port_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .eligible    (eligible),
    .rq_cyc      (rq_cyc),
    .arb_en      (state_reg == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_oh    (grant_oh),
    .grant_port  (grant_port),
    .served      (served)
  );

  // Request fields of the winning port, captured on accept
  always_comb begin
    grant_addr = ma_arr[grant_port][AW-1:0];
    grant_rd   = |(rd_rq & grant_oh);
    grant_wr   = |(wr_rq & grant_oh);
  end

  // Write restart and write data only ever come from the latched port
  always_comb begin
    wr_rs_sel = |(wr_rs & port_oh_reg);
    mb_in_sel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      mb_in_sel = mb_in_sel | (port_oh_reg[i] ? mb_in_arr[i] : '0);
    end
  end

  // Memory cycle sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset || !power) begin
      state_reg    <= ST_IDLE;
      port_oh_reg  <= '0;
      addr_reg     <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      addr_ack_reg <= 1'b0;
      rd_rs_reg    <= 1'b0;
      drive_reg    <= 1'b0;
    end else begin
      addr_ack_reg <= 1'b0;
      rd_rs_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            port_oh_reg  <= grant_oh;
            addr_reg     <= grant_addr;
            rd_reg       <= grant_rd;
            wr_reg       <= grant_wr;
            addr_ack_reg <= 1'b1;
            state_reg    <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_reg <= rd_reg ? ST_READ : ST_WAIT_WR;
        end
        ST_READ: begin
          rd_rs_reg <= 1'b1;
          drive_reg <= 1'b1;
          state_reg <= ST_RS;
        end
        ST_RS: begin
          // A read-only cycle keeps the data on the bus through DONE
          if (wr_reg) begin
            drive_reg <= 1'b0;
            state_reg <= ST_WAIT_WR;
          end else begin
            state_reg <= ST_DONE;
          end
        end
        ST_WAIT_WR: begin
          if (wr_rs_sel) begin
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          drive_reg <= 1'b0;
          state_reg <= sw_single_step ? ST_STOP : ST_IDLE;
        end
        ST_STOP: begin
          if (sw_restart) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Data register: core fetch in READ, processor data on the wr_rs edge
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else if (power && state_reg == ST_READ) begin
      data_reg <= core[addr_reg];
    end else if (power && state_reg == ST_WAIT_WR && wr_rs_sel) begin
      data_reg <= mb_in_sel;
    end
  end

  // Writes are suppressed under reset or power loss so an aborted cycle
  // leaves the word untouched
  assign ram_we = (state_reg == ST_WRITE) & power & ~reset;

  // Core write port
  always_ff @(posedge clk) begin
    if (ram_we) begin
      core[addr_reg] <= data_reg;
    end
  end

endmodule

// File: tb/tb_core_mem_161c.sv
// Directed plus randomized bench for core_mem_161c. A flat word array holds
// the expected memory image; cycle timing is taken from the membus protocol.
module tb_core_mem_161c;

  logic        clk = 1'b0;
  logic        reset, power, sw_single_step, sw_restart;
  logic [3:0]  rq_cyc, rd_rq, wr_rq, fmc, wr_rs;
  logic [14:0] ma    [4];
  logic [3:0]  sel   [4];
  logic [35:0] mb_in [4];
  logic [35:0] mb_out [4];
  logic [3:0]  addr_ack, rd_rs;

  logic [35:0] ref_mem [16384];
  logic [13:0] pool [8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_mem_161c dut (
    .clk(clk), .reset(reset), .power(power),
    .sw_single_step(sw_single_step), .sw_restart(sw_restart),
    .membus_rq_cyc_p0(rq_cyc[0]), .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]),
    .membus_ma_p0(ma[0]), .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]),
    .membus_mb_in_p0(mb_in[0]), .membus_wr_rs_p0(wr_rs[0]), .membus_mb_out_p0(mb_out[0]),
    .membus_addr_ack_p0(addr_ack[0]), .membus_rd_rs_p0(rd_rs[0]),
    .membus_rq_cyc_p1(rq_cyc[1]), .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]),
    .membus_ma_p1(ma[1]), .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]),
    .membus_mb_in_p1(mb_in[1]), .membus_wr_rs_p1(wr_rs[1]), .membus_mb_out_p1(mb_out[1]),
    .membus_addr_ack_p1(addr_ack[1]), .membus_rd_rs_p1(rd_rs[1]),
    .membus_rq_cyc_p2(rq_cyc[2]), .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]),
    .membus_ma_p2(ma[2]), .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]),
    .membus_mb_in_p2(mb_in[2]), .membus_wr_rs_p2(wr_rs[2]), .membus_mb_out_p2(mb_out[2]),
    .membus_addr_ack_p2(addr_ack[2]), .membus_rd_rs_p2(rd_rs[2]),
    .membus_rq_cyc_p3(rq_cyc[3]), .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]),
    .membus_ma_p3(ma[3]), .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]),
    .membus_mb_in_p3(mb_in[3]), .membus_wr_rs_p3(wr_rs[3]), .membus_mb_out_p3(mb_out[3]),
    .membus_addr_ack_p3(addr_ack[3]), .membus_rd_rs_p3(rd_rs[3])
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %o expected %o", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [35:0] others(input int p);
    logic [35:0] acc;
    acc = '0;
    for (int q = 0; q < 4; q++)
      if (q != p) acc = acc | mb_out[q] | {34'b0, addr_ack[q], rd_rs[q]};
    return acc;
  endfunction

  task automatic preload(input logic [13:0] a, input logic [35:0] v);
    dut.core[a] = v;
    ref_mem[a]  = v;
  endtask

  task automatic drop(input int p);
    rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
    ma[p] = '0; sel[p] = '0; fmc[p] = 1'b0;
  endtask

  // One complete membus cycle on port p; lat_exp is the expected number of
  // clocks from driving the request to seeing addr_ack
  task automatic xact(input int p, input bit rd, input bit wr, input logic [13:0] a,
                      input logic [35:0] wd, input int lat_exp, input string tag);
    int n;
    int d;
    int nb;
    logic [35:0] rdat;
    logic [63:0] junk;
    rdat = ref_mem[a];
    nb = (p + 1) % 4;
    ma[p] = {1'b0, a}; sel[p] = 4'd0; rd_rq[p] = rd; wr_rq[p] = wr; rq_cyc[p] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!addr_ack[p] && n < 40);
    chk({tag, "_ack_lat"}, 36'(n), 36'(lat_exp));
    if (!addr_ack[p]) begin
      drop(p); tick();
      return;
    end
    chk({tag, "_ack_mb"}, mb_out[p], 36'd0);
    chk({tag, "_ack_quiet"}, others(p), 36'd0);
    if (rd) begin
      tick();
      chk({tag, "_read_rs"}, {35'd0, rd_rs[p]}, 36'd0);
      tick();
      chk({tag, "_rs"}, {35'd0, rd_rs[p]}, 36'd1);
      chk({tag, "_rdata"}, mb_out[p], rdat);
      chk({tag, "_rs_quiet"}, others(p), 36'd0);
      tick();
      chk({tag, "_rs_pulse"}, {35'd0, rd_rs[p]}, 36'd0);
      chk({tag, "_mb_after_rs"}, mb_out[p], wr ? 36'd0 : rdat);
    end else begin
      tick();
      chk({tag, "_wait_mb"}, mb_out[p], 36'd0);
    end
    if (wr) begin
      // Stray wr_rs from another port must not complete the cycle
      d = $urandom_range(0, 2);
      repeat (d) begin
        junk = {$urandom(), $urandom()};
        wr_rs[nb] = 1'b1; mb_in[nb] = junk[35:0];
        tick();
        wr_rs[nb] = 1'b0; mb_in[nb] = '0;
        chk({tag, "_stray_mb"}, mb_out[p], 36'd0);
      end
      mb_in[p] = wd; wr_rs[p] = 1'b1;
      tick();
      wr_rs[p] = 1'b0; mb_in[p] = '0;
      tick();
      ref_mem[a] = wd;
      chk({tag, "_commit"}, dut.core[a], ref_mem[a]);
      chk({tag, "_wr_mb"}, mb_out[p] | others(p), 36'd0);
    end
    tick();
    drop(p);
    tick();
    chk({tag, "_idle_mb"}, mb_out[p] | others(p), 36'd0);
  endtask

  // Counts addr_acks on any port over a window of clocks
  task automatic no_ack(input int cycles, input string tag);
    int acks;
    acks = 0;
    repeat (cycles) begin
      tick();
      acks += int'($countones(addr_ack));
      if (mb_out[0] != 0 || mb_out[1] != 0 || mb_out[2] != 0 || mb_out[3] != 0) acks++;
    end
    chk(tag, 36'(acks), 36'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack1_at, ack3_at, rs1_at, rs3_at, ack1_n, ack3_n;
    logic [35:0] d1, d3;
    logic [13:0] a;
    logic [63:0] r64;
    int p, op;

    reset = 1'b1; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
    rq_cyc = '0; rd_rq = '0; wr_rq = '0; fmc = '0; wr_rs = '0;
    for (int i = 0; i < 4; i++) begin ma[i] = '0; sel[i] = '0; mb_in[i] = '0; end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk("reset_ack", {35'd0, addr_ack[i]}, 36'd0);
      chk("reset_rs", {35'd0, rd_rs[i]}, 36'd0);
      chk("reset_mb", mb_out[i], 36'd0);
    end
    reset = 1'b0;
    tick();

    // Directed read, write and read-modify-write on p0
    preload(14'o105, 36'o1234);
    xact(0, 1'b1, 1'b0, 14'o105, 36'd0, 1, "rd105");
    preload(14'o100, 36'o0);
    xact(0, 1'b0, 1'b1, 14'o100, 36'o777, 1, "wr100");
    preload(14'o1323, 36'o215000000001);
    xact(0, 1'b1, 1'b1, 14'o1323, 36'o5, 1, "rmw1323");
    xact(2, 1'b1, 1'b0, 14'o100, 36'd0, 1, "rd100");

    // p1 and p3 collide; p1 holds rq_cyc throughout and must not be re-acked
    preload(14'o2001, 36'o111111111111);
    preload(14'o2003, 36'o333333333333);
    ma[1] = 15'o2001; rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1;
    ma[3] = 15'o2003; rd_rq[3] = 1'b1; rq_cyc[3] = 1'b1;
    ack1_at = -1; ack3_at = -1; rs1_at = -1; rs3_at = -1; ack1_n = 0; ack3_n = 0;
    d1 = '0; d3 = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (addr_ack[1]) begin ack1_n++; if (ack1_at < 0) ack1_at = c; end
      if (addr_ack[3]) begin ack3_n++; if (ack3_at < 0) ack3_at = c; end
      if (rd_rs[1] && rs1_at < 0) begin rs1_at = c; d1 = mb_out[1]; end
      if (rd_rs[3] && rs3_at < 0) begin rs3_at = c; d3 = mb_out[3]; end
    end
    chk("arb_p1_ack_at", 36'(ack1_at), 36'd1);
    chk("arb_p3_ack_at", 36'(ack3_at), 36'd6);
    chk("arb_p1_rs_at", 36'(rs1_at), 36'd3);
    chk("arb_p3_rs_at", 36'(rs3_at), 36'd8);
    chk("arb_p1_data", d1, ref_mem[14'o2001]);
    chk("arb_p3_data", d3, ref_mem[14'o2003]);
    chk("arb_p1_acks", 36'(ack1_n), 36'd1);
    chk("arb_p3_acks", 36'(ack3_n), 36'd1);
    drop(1); drop(3);
    tick();

    // Requests this module must ignore
    ma[0] = 15'o105; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; fmc[0] = 1'b1;
    no_ack(8, "ign_fmc");
    drop(0); tick();
    ma[2] = 15'o105; sel[2] = 4'd1; rd_rq[2] = 1'b1; rq_cyc[2] = 1'b1;
    no_ack(8, "ign_sel");
    drop(2); tick();
    ma[1] = 15'o40105; rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1;
    no_ack(8, "ign_ma21");
    drop(1); tick();
    ma[0] = 15'o105; rq_cyc[0] = 1'b1;
    no_ack(8, "ign_no_rdwr");
    drop(0); tick();
    power = 1'b0;
    ma[3] = 15'o105; rd_rq[3] = 1'b1; rq_cyc[3] = 1'b1;
    no_ack(8, "ign_power");
    drop(3); tick();
    power = 1'b1;
    tick();
    xact(3, 1'b1, 1'b0, 14'o105, 36'd0, 1, "after_power");

    // Single step: the second request waits in STOP until a restart pulse
    sw_single_step = 1'b1;
    xact(0, 1'b1, 1'b0, 14'o100, 36'd0, 1, "ss_first");
    fork
      begin
        repeat (6) @(negedge clk);
        sw_restart = 1'b1; sw_single_step = 1'b0;
        @(negedge clk);
        sw_restart = 1'b0;
      end
    join_none
    xact(1, 1'b1, 1'b0, 14'o1323, 36'd0, 8, "ss_second");

    // Reset while waiting for write data: cycle aborted, word unchanged
    preload(14'o3070, 36'o707070707070);
    ma[2] = 15'o3070; wr_rq[2] = 1'b1; rq_cyc[2] = 1'b1;
    tick();
    chk("rst_ack", {35'd0, addr_ack[2]}, 36'd1);
    tick();
    reset = 1'b1; drop(2);
    tick();
    reset = 1'b0;
    chk("rst_quiet", others(-1), 36'd0);
    wr_rs[2] = 1'b1; mb_in[2] = 36'o123;
    tick();
    wr_rs[2] = 1'b0; mb_in[2] = '0;
    repeat (3) tick();
    chk("rst_word_kept", dut.core[14'o3070], ref_mem[14'o3070]);
    xact(2, 1'b1, 1'b0, 14'o3070, 36'd0, 1, "rst_readback");

    // Randomized traffic over a small address pool so words get reused
    for (int i = 0; i < 8; i++) begin
      pool[i] = 14'($urandom_range(0, 16383));
      r64 = {$urandom(), $urandom()};
      preload(pool[i], r64[35:0]);
    end
    for (int t = 0; t < 40; t++) begin
      p  = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 2));
      a  = pool[$urandom_range(0, 7)];
      r64 = {$urandom(), $urandom()};
      xact(p, op != 1, op != 0, a, r64[35:0], 1, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_mem_161c.md
# core_mem_161c

Four-port 16K × 36-bit core memory module (type 161C behavioural model) on the PDP-6 memory bus. It arbitrates requests from up to four processor ports (p0–p3) and performs read, write and read-modify-write cycles using the membus handshake (rq_cyc/rd_rq/wr_rq → addr_ack → rd_rs / wr_rs). It sits beside the fast memory on the wired-OR membus of the apr.

## Interface
- MEMSEL, 5'd0: module number; the module responds when {membus_sel_pN[18:21], membus_ma_pN[21]} == MEMSEL.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- power  in  1  0 = module dead: no acks, all outputs 0.
- sw_single_step  in  1  1 = halt in STOP after each completed cycle.
- sw_restart  in  1  high at a clock edge releases STOP.
- Per port pN, N = 0..3:
  - membus_rq_cyc_pN  in  1  cycle request.
  - membus_rd_rq_pN  in  1  read requested.
  - membus_wr_rq_pN  in  1  write requested.
  - membus_ma_pN[21:35]  in  15  address; [22:35] is the word index.
  - membus_sel_pN[18:21]  in  4  memory select.
  - membus_fmc_select_pN  in  1  fast-memory select; while 1 this module ignores the port.
  - membus_mb_in_pN[0:35]  in  36  write data (wired-OR bus).
  - membus_wr_rs_pN  in  1  write restart (processor data valid).
  - membus_mb_out_pN[0:35]  out  36  read data; 0 whenever not driving.
  - membus_addr_ack_pN  out  1  address acknowledge, one-cycle pulse.
  - membus_rd_rs_pN  out  1  read restart, one-cycle pulse.
- Storage array `core[0:16383]` of 36-bit words, directly addressable by benches for preloading.

## Operation
- Port N is eligible when all of the following hold: power=1, rq_cyc=1, fmc_select=0, select matches MEMSEL, (rd_rq | wr_rq)=1, and the port is not "served".
- If rq_cyc=1 with neither rd_rq nor wr_rq set, the request is ignored.
- Arbitration occurs only in IDLE, with fixed priority p0 > p1 > p2 > p3.
- On accept, latch the port number, address [22:35], rd flag and wr flag. Set served[N]; served[N] clears in any cycle where rq_cyc_pN=0.
- State machine: IDLE → ACK → (rd ? READ → RS : WAIT_WR).
  - RS → WAIT_WR if wr, else DONE.
  - WAIT_WR → WRITE on wr_rs of the latched port.
  - WRITE → DONE.
  - DONE → STOP if sw_single_step, else IDLE.
  - STOP → IDLE on sw_restart.
- ACK: addr_ack of the latched port is 1 for exactly one cycle.
- READ: fetch core[addr] into the data register.
- RS: rd_rs=1 for one cycle and mb_out = data register. On a read-only cycle mb_out also stays valid through DONE. On a read-modify-write cycle mb_out is 0 from the cycle after RS.
- WRITE: core[addr] ← membus_mb_in_pN of the latched port, as sampled on the wr_rs edge.
- Only the latched port's outputs are ever nonzero. Other ports' outputs stay 0; no bus contention on the wired-OR bus.
- power=0: state is forced to IDLE and all outputs are 0. Core contents are preserved.
- reset: state IDLE, served=0, all outputs 0, data register 0. Core contents are not cleared.
- A wr_rs from a non-latched port, or a wr_rs outside WAIT_WR, is ignored.

## Timing
- Request sampled high at edge E: addr_ack high in cycle E+1, READ at E+2, rd_rs with data at E+3, DONE at E+4, IDLE at E+5. Read-only total is 5 cycles.
- Write-only: ACK at E+1, WAIT_WR from E+2. wr_rs sampled at edge W: write committed at W+1, IDLE at W+3.
- Read-modify-write: read timing as above, then the write-only tail.
- Back-to-back: a new accept is possible on the first IDLE edge. A held rq_cyc on an already-served port is not re-accepted until it drops for at least one cycle.
- Simultaneous requests: lower-numbered port wins; the loser stays pending and is served next.
- Reset mid-cycle aborts it. A pending write is lost and outputs drop to 0 the next cycle.

## Structure
- Shared package: state enum (IDLE, ACK, READ, RS, WAIT_WR, WRITE, DONE, STOP) and constants WORDS = 16384, WIDTH = 36.
- One natural sub-module: `membus_port_arb`, a 4-way fixed-priority arbiter with served flags.
- The RAM array stays inline, named `core`.

## Test plan
- Preload core['o105] = 36'o1234. p0 read at ma 'o105, sel 0 → addr_ack at E+1; rd_rs at E+3 with mb_out = 36'o1234; mb_out = 0 after DONE.
- p0 write 'o100 with wr_rs and mb_in = 36'o777 → core['o100] = 36'o777. mb_out stays 0 throughout.
- p0 read-modify-write at 'o1323 (preloaded 36'o215000000001) → rd_rs data 36'o215000000001. Then wr_rs with 36'o5 → core['o1323] = 36'o5.
- p1 and p3 request in the same cycle → p1 is acked first and p3 afterwards. A held rq_cyc on p1 is not re-acked.
- fmc_select = 1 or sel ≠ MEMSEL → no addr_ack. power = 0 → no outputs.
- sw_single_step = 1 → a second request waits in STOP until a sw_restart pulse. Reset during WAIT_WR → IDLE and the target word is unchanged.
